// File: rtl/pipe_out_generate_pkg.sv
// pipe_out_generate_pkg: pattern mode encodings and generator constants for the Pipe Out source.
package pipe_out_generate_pkg;

    typedef enum logic [2:0] {
        PAT_FIXED = 3'd0,
        PAT_COUNT = 3'd1,
        PAT_WALK  = 3'd2,
        PAT_LFSR  = 3'd3
    } pat_mode_t;

    localparam logic [31:0] LFSR_SEED     = 32'h0D0C_0B0A;
    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
    localparam logic [31:0] THROTTLE_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_out_pattern.sv
// pipe_out_pattern: deterministic word sequence that advances one word per host read.
module pipe_out_pattern
    import pipe_out_generate_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] fixed_pattern,
    output logic [WIDTH-1:0] dout
);

    logic             fresh;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] next;

    // While fresh, the mode's start word is shown so reset needs no mode-dependent value
    always_comb begin
        start = mode == PAT_WALK ? WIDTH'(1) : mode == PAT_LFSR ? WIDTH'(LFSR_SEED) : '0;
        base  = fresh ? start : state;
        next  = mode == PAT_COUNT ? base + 1'b1 :
                mode == PAT_WALK  ? {base[WIDTH-2:0], base[WIDTH-1]} :
                mode == PAT_LFSR  ? (base >> 1) ^ (base[0] ? WIDTH'(LFSR_TAPS) : '0) : base;
        dout  = (mode == PAT_COUNT || mode == PAT_WALK || mode == PAT_LFSR) ? base : fixed_pattern;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fresh <= 1'b1;
            state <= '0;
        end else begin
            fresh <= 1'b0;
            state <= advance ? next : base;
        end
    end

endmodule

// File: rtl/pipe_out_generate.sv
// pipe_out_generate: throttled virtual FIFO feeding a host Pipe Out with a pattern sequence.
module pipe_out_generate
    import pipe_out_generate_pkg::*;
#(
    parameter int DEPTH       = 65536,
    parameter int BLOCK_WORDS = 1024,
    parameter int LVL_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_out_read,
    output logic [31:0] pipe_out_data,
    output logic        pipe_out_ready,
    input  logic        throttle_set,
    input  logic [31:0] throttle_val,
    input  logic [31:0] fixed_pattern,
    input  logic [2:0]  pattern,
    output logic [31:0] underflow_count
);

    logic [31:0]      throttle;
    logic [LVL_W-1:0] level;
    logic             fill;

    assign fill = throttle[0];

    // A simultaneous fill and read cancel out, so neither moves the level nor underflows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            throttle        <= THROTTLE_INIT;
            level           <= '0;
            pipe_out_ready  <= 1'b0;
            underflow_count <= '0;
        end else begin
            throttle       <= throttle_set ? throttle_val : {throttle[0], throttle[31:1]};
            pipe_out_ready <= level >= LVL_W'(BLOCK_WORDS);
            if (fill && !pipe_out_read) begin
                if (level != LVL_W'(DEPTH))
                    level <= level + 1'b1;
            end else if (!fill && pipe_out_read) begin
                if (level != '0)
                    level <= level - 1'b1;
                else if (underflow_count != '1)
                    underflow_count <= underflow_count + 1'b1;
            end
        end
    end

    pipe_out_pattern #(.WIDTH(32)) u_pattern (
        .clk           (clk),
        .reset         (reset),
        .advance       (pipe_out_read),
        .mode          (pattern),
        .fixed_pattern (fixed_pattern),
        .dout          (pipe_out_data)
    );

endmodule

// File: tb/tb_pipe_out_generate.sv
// tb_pipe_out_generate: directed stimulus against a word-count/level model of the Pipe Out source.
module tb_pipe_out_generate;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pipe_out_read = 1'b0;
    logic        throttle_set = 1'b0;
    logic [31:0] throttle_val = '0;
    logic [31:0] fixed_pattern = '0;
    logic [2:0]  pattern = 3'd1;
    logic [31:0] pipe_out_data;
    logic        pipe_out_ready;
    logic [31:0] underflow_count;

    int total = 0;
    int bad = 0;

    pipe_out_generate dut (
        .clk             (clk),
        .reset           (reset),
        .pipe_out_read   (pipe_out_read),
        .pipe_out_data   (pipe_out_data),
        .pipe_out_ready  (pipe_out_ready),
        .throttle_set    (throttle_set),
        .throttle_val    (throttle_val),
        .fixed_pattern   (fixed_pattern),
        .pattern         (pattern),
        .underflow_count (underflow_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: word index since reset, FIFO occupancy as a plain integer
    logic [31:0] m_thr = 32'hFFFF_FFFF;
    logic [31:0] m_n = '0;
    logic [31:0] m_lfsr = 32'h0D0C_0B0A;
    logic [31:0] m_uf = '0;
    int          m_lvl = 0;
    logic        m_ready = 1'b0;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] exp_word();
        case (pattern)
            3'd1:    return m_n;
            3'd2:    return 32'h1 << m_n[4:0];
            3'd3:    return m_lfsr;
            default: return fixed_pattern;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_thr = 32'hFFFF_FFFF;
            m_n = '0;
            m_lfsr = 32'h0D0C_0B0A;
            m_uf = '0;
            m_lvl = 0;
            m_ready = 1'b0;
        end else begin
            m_ready = m_lvl >= 1024;
            if (m_thr[0] && !pipe_out_read)
                m_lvl = (m_lvl < 65536) ? m_lvl + 1 : 65536;
            else if (!m_thr[0] && pipe_out_read) begin
                if (m_lvl > 0) m_lvl = m_lvl - 1;
                else if (m_uf != 32'hFFFF_FFFF) m_uf = m_uf + 1;
            end
            m_thr = throttle_set ? throttle_val : ((m_thr >> 1) | (m_thr << 31));
            if (pipe_out_read) begin
                m_n = m_n + 1;
                m_lfsr = lfsr_step(m_lfsr);
            end
        end
    end

    always @(negedge clk) begin
        check("data", pipe_out_data, exp_word());
        check("ready", {31'd0, pipe_out_ready}, {31'd0, m_ready});
        check("underflow", underflow_count, m_uf);
        check("level", 32'(dut.level), 32'(m_lvl));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] m);
        pattern = m;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input int limit, output int c);
        c = 0;
        while (!pipe_out_ready && c < limit) begin
            tick();
            c++;
        end
        check(nm, {31'd0, pipe_out_ready}, 32'd1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        #1 reset = 1'b1;
        #1;
        check("rst_ready", {31'd0, pipe_out_ready}, 32'd0);
        check("rst_data", pipe_out_data, 32'd0);
        check("rst_uf", underflow_count, 32'd0);
        tick();
        reset = 1'b0;

        wait_ready("ready_rise", 1100, c);
        check("ready_latency", c, 32'd1025);
        pipe_out_read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("count_data", pipe_out_data, 32'(i));
            tick();
        end
        pipe_out_read = 1'b0;
        check("count_after", pipe_out_data, 32'd8);
        tick();
        check("count_hold", pipe_out_data, 32'd8);
        repeat (65000) tick();
        check("sat_level", 32'(dut.level), 32'd65536);

        do_reset(3'd1);
        throttle_set = 1'b1;
        throttle_val = 32'h1111_1111;
        tick();
        throttle_set = 1'b0;
        wait_ready("quarter_rise", 5000, c);
        check("quarter_latency", c, 32'd4090);

        do_reset(3'd2);
        throttle_set = 1'b1;
        throttle_val = 32'h0;
        pipe_out_read = 1'b1;
        tick();
        throttle_set = 1'b0;
        check("hold11_uf", underflow_count, 32'd0);
        check("hold11_level", 32'(dut.level), 32'd0);
        repeat (5) tick();
        pipe_out_read = 1'b0;
        check("uf_count", underflow_count, 32'd5);
        check("uf_level", 32'(dut.level), 32'd0);
        check("walk_data", pipe_out_data, 32'h40);
        tick();

        fixed_pattern = 32'h1234_5678;
        do_reset(3'd5);
        check("fixed_a", pipe_out_data, 32'h1234_5678);
        fixed_pattern = 32'hCAFE_F00D;
        #1;
        check("fixed_b", pipe_out_data, 32'hCAFE_F00D);
        pipe_out_read = 1'b1;
        repeat (3) tick();
        pipe_out_read = 1'b0;
        tick();

        do_reset(3'd3);
        check("lfsr_seed", pipe_out_data, 32'h0D0C_0B0A);
        wait_ready("lfsr_ready", 1100, c);
        pipe_out_read = 1'b1;
        check("lfsr_w0", pipe_out_data, 32'h0D0C_0B0A);
        tick();
        check("lfsr_w1", pipe_out_data, 32'h0686_0585);
        tick();
        check("lfsr_w2", pipe_out_data, 32'h8363_02C1);
        tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_ready", {31'd0, pipe_out_ready}, 32'd0);
        check("midrst_data", pipe_out_data, 32'h0D0C_0B0A);
        check("midrst_level", 32'(dut.level), 32'd0);
        pipe_out_read = 1'b0;
        tick();
        reset = 1'b0;
        pipe_out_read = 1'b1;
        check("restart_w0", pipe_out_data, 32'h0D0C_0B0A);
        tick();
        check("restart_w1", pipe_out_data, 32'h0686_0585);
        pipe_out_read = 1'b0;
        tick();
        check("restart_hold", pipe_out_data, 32'h0686_0585);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
